mpu_matrix_loader: RTL and testbench

Serial-to-parallel matrix assembler for the MPU. It accepts signed 8-bit matrix elements one per beat over a valid/ready stream, in row-major order. It packs them into the 5x5 flat matrix bus that the MPU operation units (determinant and the others) consume. When the last element of an N x N matrix is accepted, it presents the bus with its size and a valid flag.

---
 rtl/mpu_matrix_loader.sv | 102 ++++++++++
 tb/tb_mpu_matrix_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_matrix_loader.sv
// Serial-to-parallel loader: packs a row-major stream of signed bytes
// into the 5x5 MPU matrix bus and flags it valid when complete.
module mpu_matrix_loader (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic signed [7:0] size,
   input  logic signed [7:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [0:199]      matrix,
   output logic signed [7:0] matrix_size,
   output logic              matrix_valid,
   output logic              busy,
   output logic              error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   logic [2:0] row;
   logic [2:0] col;
   logic [2:0] last_idx;
   logic       legal;
   logic       beat;

   assign legal    = (size >= 8'sd1) && (size <= 8'sd5);
   assign last_idx = matrix_size[2:0] - 3'd1;
   assign beat     = in_valid && in_ready;

   // in_ready/busy are registered copies of the LOAD state
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= IDLE;
         matrix       <= '0;
         matrix_size  <= '0;
         matrix_valid <= 1'b0;
         busy         <= 1'b0;
         in_ready     <= 1'b0;
         error        <= 1'b0;
         row          <= '0;
         col          <= '0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  matrix_valid <= 1'b0;
                  if (legal) begin
                     matrix_size <= size;
                     matrix      <= '0;
                     row         <= '0;
                     col         <= '0;
                     error       <= 1'b0;
                     in_ready    <= 1'b1;
                     busy        <= 1'b1;
                     state       <= LOAD;
                  end else begin
                     error <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
            LOAD: begin
               if (beat) begin
                  for (int r = 0; r < 5; r++) begin
                     for (int c = 0; c < 5; c++) begin
                        if (row == 3'(r) && col == 3'(c)) begin
                           matrix[40*r+8*c +: 8] <= in_data;
                        end
                     end
                  end
                  if (col == last_idx) begin
                     col <= '0;
                     if (row == last_idx) begin
                        row          <= '0;
                        in_ready     <= 1'b0;
                        busy         <= 1'b0;
                        matrix_valid <= 1'b1;
                        state        <= DONE;
                     end else begin
                        row <= row + 3'd1;
                     end
                  end else begin
                     col <= col + 3'd1;
                  end
               end
            end
            default: begin
               state        <= IDLE;
               in_ready     <= 1'b0;
               busy         <= 1'b0;
               matrix_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Scoreboard bench for mpu_matrix_loader: elements pushed as they are
// accepted, the expected bus rebuilt from the queue when valid rises.
module tb_mpu_matrix_loader;

   logic              clock;
   logic              reset;
   logic              start;
   logic signed [7:0] size;
   logic signed [7:0] in_data;
   logic              in_valid;
   logic              in_ready;
   logic [0:199]      matrix;
   logic signed [7:0] matrix_size;
   logic              matrix_valid;
   logic              busy;
   logic              error;

   typedef struct {
      int                off;
      logic signed [7:0] val;
   } sb_t;

   sb_t               sb[$];
   sb_t               e;
   logic [0:199]      exp;
   logic signed [7:0] vals [25];
   int                errors;
   int                checks;

   mpu_matrix_loader dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .size(size),
      .in_data(in_data),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .matrix(matrix),
      .matrix_size(matrix_size),
      .matrix_valid(matrix_valid),
      .busy(busy),
      .error(error)
   );

   always #5 clock = ~clock;

   task automatic do_start(input logic signed [7:0] sz);
      start = 1'b1;
      size  = sz;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic stream(input int n, input int first, input int last,
                         input bit gaps, output int cycles,
                         output bit allrdy);
      int k;
      k      = first;
      cycles = 0;
      allrdy = 1'b1;
      while (k < last && cycles < 200) begin
         in_valid = !(gaps && (cycles % 3 == 2));
         in_data  = vals[k];
         if (!in_ready) allrdy = 1'b0;
         if (in_valid && in_ready) begin
            sb.push_back('{off: 40*(k/n) + 8*(k%n), val: vals[k]});
            k++;
         end
         @(posedge clock);
         #1;
         cycles++;
      end
      in_valid = 1'b0;
      if (k < last) begin
         checks++;
         errors++;
         $display("FAIL stream_timeout beats=%0d required=%0d", k, last);
      end
   endtask

   task automatic build_exp();
      exp = '0;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         exp[e.off +: 8] = e.val;
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #12;
      checks++;
      if ({matrix_valid, busy, in_ready, error} !== 4'b0 ||
          matrix !== '0 || matrix_size !== 8'sd0) begin
         errors++;
         $display("FAIL reset_outputs v=%b b=%b r=%b e=%b sz=%0d required all 0",
                  matrix_valid, busy, in_ready, error, matrix_size);
      end
      reset = 1'b0;
      @(posedge clock);
      #1;
   endtask

   task automatic test_load2();
      int cyc;
      bit rdy;
      logic signed [7:0] b;
      vals[0] = 3; vals[1] = -2; vals[2] = 7; vals[3] = 5;
      do_start(8'sd2);
      stream(2, 0, 4, 1'b0, cyc, rdy);
      checks++;
      if (matrix_valid !== 1'b1 || cyc != 4) begin
         errors++;
         $display("FAIL load2_latency valid=%b cycles=%0d required 1/4",
                  matrix_valid, cyc);
      end
      build_exp();
      checks++;
      if (matrix !== exp) begin
         errors++;
         $display("FAIL load2_matrix got=%h required=%h", matrix, exp);
      end
      b = matrix[8 +: 8];
      checks++;
      if (b !== -8'sd2 || matrix_size !== 8'sd2) begin
         errors++;
         $display("FAIL load2_elem01 got=%0d size=%0d required -2/2",
                  b, matrix_size);
      end
   endtask

   task automatic test_gaps5();
      int cyc;
      bit rdy;
      for (int i = 0; i < 25; i++) vals[i] = 8'(i + 1);
      do_start(8'sd5);
      stream(5, 0, 25, 1'b1, cyc, rdy);
      checks++;
      if (rdy !== 1'b1 || cyc != 37 || matrix_valid !== 1'b1) begin
         errors++;
         $display("FAIL gaps5_timing ready=%b cycles=%0d valid=%b required 1/37/1",
                  rdy, cyc, matrix_valid);
      end
      build_exp();
      checks++;
      if (matrix !== exp || matrix_size !== 8'sd5) begin
         errors++;
         $display("FAIL gaps5_matrix got=%h required=%h", matrix, exp);
      end
   endtask

   task automatic test_illegal();
      logic signed [7:0] bad [3];
      bad[0] = 8'sd0; bad[1] = 8'sd6; bad[2] = -8'sd1;
      for (int i = 0; i < 3; i++) begin
         do_start(bad[i]);
         checks++;
         if (error !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0 ||
             matrix_valid !== 1'b0 || matrix !== exp) begin
            errors++;
            $display("FAIL illegal_%0d e=%b b=%b r=%b v=%b required 1/0/0/0 unchanged",
                     bad[i], error, busy, in_ready, matrix_valid);
         end
      end
      do_start(8'sd3);
      checks++;
      if (error !== 1'b0 || busy !== 1'b1 || matrix_size !== 8'sd3 ||
          matrix !== '0) begin
         errors++;
         $display("FAIL illegal_recover e=%b b=%b sz=%0d required 0/1/3",
                  error, busy, matrix_size);
      end
   endtask

   task automatic test_async_reset();
      int cyc;
      bit rdy;
      for (int i = 0; i < 9; i++) vals[i] = 8'(10 + i);
      stream(3, 0, 4, 1'b0, cyc, rdy);
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({matrix_valid, busy, in_ready, error} !== 4'b0 ||
          matrix !== '0 || matrix_size !== 8'sd0) begin
         errors++;
         $display("FAIL async_reset v=%b b=%b r=%b m=%h required zeros",
                  matrix_valid, busy, in_ready, matrix);
      end
      reset = 1'b0;
      sb.delete();
      vals[0] = -8'sd128;
      do_start(8'sd1);
      stream(1, 0, 1, 1'b0, cyc, rdy);
      build_exp();
      checks++;
      if (matrix_valid !== 1'b1 || cyc != 1 || matrix !== exp) begin
         errors++;
         $display("FAIL after_reset_n1 valid=%b cycles=%0d m=%h required 1/1/%h",
                  matrix_valid, cyc, matrix, exp);
      end
   endtask

   task automatic test_ignore_start();
      int cyc;
      bit rdy;
      for (int i = 0; i < 9; i++) vals[i] = 8'(-20 + 5*i);
      do_start(8'sd3);
      stream(3, 0, 4, 1'b0, cyc, rdy);
      do_start(8'sd5);
      checks++;
      if (busy !== 1'b1 || matrix_size !== 8'sd3 || matrix_valid !== 1'b0) begin
         errors++;
         $display("FAIL ignore_start b=%b sz=%0d v=%b required 1/3/0",
                  busy, matrix_size, matrix_valid);
      end
      stream(3, 4, 8, 1'b0, cyc, rdy);
      in_valid = 1'b1;
      in_data  = vals[8];
      start    = 1'b1;
      size     = 8'sd5;
      sb.push_back('{off: 80 + 16, val: vals[8]});
      @(posedge clock);
      #1;
      start    = 1'b0;
      in_valid = 1'b0;
      build_exp();
      checks++;
      if (matrix_valid !== 1'b1 || busy !== 1'b0 || matrix_size !== 8'sd3 ||
          matrix !== exp) begin
         errors++;
         $display("FAIL start_on_last v=%b b=%b sz=%0d m=%h required 1/0/3/%h",
                  matrix_valid, busy, matrix_size, matrix, exp);
      end
   endtask

   task automatic test_back_to_back();
      int cyc;
      bit rdy;
      vals[0] = 11; vals[1] = 22; vals[2] = 33; vals[3] = 44;
      do_start(8'sd2);
      stream(2, 0, 4, 1'b0, cyc, rdy);
      build_exp();
      checks++;
      if (matrix_valid !== 1'b1 || matrix !== exp) begin
         errors++;
         $display("FAIL b2b_first v=%b m=%h required 1/%h",
                  matrix_valid, matrix, exp);
      end
      do_start(8'sd1);
      checks++;
      if (matrix_valid !== 1'b0 || matrix !== '0 || matrix_size !== 8'sd1) begin
         errors++;
         $display("FAIL b2b_clear v=%b sz=%0d m=%h required 0/1/0",
                  matrix_valid, matrix_size, matrix);
      end
      vals[0] = 9;
      stream(1, 0, 1, 1'b0, cyc, rdy);
      build_exp();
      checks++;
      if (matrix_valid !== 1'b1 || matrix !== exp || cyc != 1) begin
         errors++;
         $display("FAIL b2b_second v=%b cycles=%0d m=%h required 1/1/%h",
                  matrix_valid, cyc, matrix, exp);
      end
   endtask

   initial begin
      clock    = 1'b0;
      reset    = 1'b1;
      start    = 1'b0;
      size     = '0;
      in_data  = '0;
      in_valid = 1'b0;
      errors   = 0;
      checks   = 0;
      exp      = '0;
      test_reset();
      test_load2();
      test_gaps5();
      test_illegal();
      test_async_reset();
      test_ignore_start();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
